// File: rtl/scene_pattern_source_pkg.sv
// Shared types and default geometry for the scene pattern source and its pixel generator.
package scene_pattern_source_pkg;

    localparam int DEF_PIXEL_ARRAY_WIDTH  = 24;
    localparam int DEF_PIXEL_ARRAY_HEIGHT = 12;
    localparam int DEF_PIXEL_BITS         = 8;
    localparam int DEF_OUTPUT_BUS_WIDTH   = 8;
    localparam int DEF_GRAD_STEP          = 10;
    localparam int DEF_CHECK_LOG2         = 2;
    localparam int BEATS_PER_ROW          = DEF_PIXEL_ARRAY_WIDTH / DEF_OUTPUT_BUS_WIDTH;

    typedef enum logic [1:0] {
        CONSTANT = 2'd0,
        GRADIENT = 2'd1,
        CHECKER  = 2'd2,
        MOVING   = 2'd3
    } scene_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } scene_state_t;

endpackage

// File: rtl/scene_pattern_source_pixel_gen.sv
// Combinational pattern function for one lane: (mode, x, y, frame count, constant) -> pixel.
module scene_pixel_gen
    import scene_pattern_source_pkg::*;
#(
    parameter int PIXEL_BITS = DEF_PIXEL_BITS,
    parameter int X_W        = 5,
    parameter int Y_W        = 4,
    parameter int GRAD_STEP  = DEF_GRAD_STEP,
    parameter int CHECK_LOG2 = DEF_CHECK_LOG2
) (
    input  scene_mode_t             i_mode,
    input  logic [X_W-1:0]          i_x,
    input  logic [Y_W-1:0]          i_y,
    input  logic [7:0]              i_frame_count,
    input  logic [PIXEL_BITS-1:0]   i_const_value,
    output logic [PIXEL_BITS-1:0]   o_pixel
);

    logic [PIXEL_BITS-1:0] w_x;
    logic [PIXEL_BITS-1:0] w_y;
    logic [PIXEL_BITS-1:0] w_fc;
    logic                  w_check_bit;

    // Low PIXEL_BITS of a product/sum depend only on low operand bits, so work at pixel width.
    assign w_x         = PIXEL_BITS'(i_x);
    assign w_y         = PIXEL_BITS'(i_y);
    assign w_fc        = PIXEL_BITS'(i_frame_count);
    assign w_check_bit = i_x[CHECK_LOG2] ^ i_y[CHECK_LOG2];

    always_comb begin
        o_pixel = '0;
        case (i_mode)
            CONSTANT: o_pixel = i_const_value;
            GRADIENT: o_pixel = w_x * PIXEL_BITS'(GRAD_STEP) + w_y;
            CHECKER:  o_pixel = w_check_bit ? '1 : '0;
            MOVING:   o_pixel = w_x + w_y + w_fc;
            default:  o_pixel = '0;
        endcase
    end

endmodule

// File: rtl/scene_pattern_source.sv
// Streams generated scene frames row-major, OUTPUT_BUS_WIDTH pixels per beat, over valid/ready.
module scene_pattern_source
    import scene_pattern_source_pkg::*;
#(
    parameter int PIXEL_ARRAY_WIDTH  = DEF_PIXEL_ARRAY_WIDTH,
    parameter int PIXEL_ARRAY_HEIGHT = DEF_PIXEL_ARRAY_HEIGHT,
    parameter int PIXEL_BITS         = DEF_PIXEL_BITS,
    parameter int OUTPUT_BUS_WIDTH   = DEF_OUTPUT_BUS_WIDTH,
    parameter int GRAD_STEP          = DEF_GRAD_STEP,
    parameter int CHECK_LOG2         = DEF_CHECK_LOG2
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_start,
    input  logic                                   i_stop,
    input  logic [1:0]                             i_mode,
    input  logic [PIXEL_BITS-1:0]                  i_const_value,
    input  logic [7:0]                             i_frames,
    output logic                                   o_out_valid,
    input  logic                                   i_out_ready,
    output logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0] o_out_data,
    output logic                                   o_out_first,
    output logic                                   o_out_last,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic [7:0]                             o_frame_count
);

    localparam int BPR    = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int X_W    = (PIXEL_ARRAY_WIDTH > 1) ? $clog2(PIXEL_ARRAY_WIDTH) : 1;
    localparam int Y_W    = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int BEAT_W = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int DATA_W = OUTPUT_BUS_WIDTH * PIXEL_BITS;

    scene_state_t          r_state, w_state_next;
    scene_mode_t           r_mode, w_mode_sel;
    logic [PIXEL_BITS-1:0] r_const, w_const_sel;
    logic [7:0]            r_frames;
    logic                  r_stop_pend;
    logic [BEAT_W-1:0]     r_beat, w_beat_next;
    logic [Y_W-1:0]        r_row, w_row_next;
    logic [7:0]            r_fc, w_fc_next, w_fc_inc;
    logic                  r_valid, w_valid_next, w_load;
    logic [DATA_W-1:0]     r_data, w_pixels;
    logic                  r_first, r_last;
    logic                  w_xfer, w_beat_end, w_row_end, w_frame_end, w_run_end;

    assign w_xfer      = r_valid & i_out_ready;
    assign w_beat_end  = (r_beat == BEAT_W'(BPR - 1));
    assign w_row_end   = (r_row == Y_W'(PIXEL_ARRAY_HEIGHT - 1));
    assign w_frame_end = w_xfer & w_beat_end & w_row_end;
    assign w_fc_inc    = (r_fc == 8'hFF) ? r_fc : r_fc + 8'd1;
    // A stop arriving on the very last beat still counts as pending for this frame.
    assign w_run_end   = w_frame_end &
                         (((r_frames != 8'd0) && ({1'b0, r_fc} + 9'd1 == {1'b0, r_frames}))
                          | r_stop_pend | i_stop);

    always_comb begin
        w_state_next = r_state;
        w_beat_next  = r_beat;
        w_row_next   = r_row;
        w_fc_next    = r_fc;
        w_mode_sel   = r_mode;
        w_const_sel  = r_const;
        w_valid_next = r_valid;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_STREAM;
                    w_beat_next  = '0;
                    w_row_next   = '0;
                    w_fc_next    = '0;
                    w_mode_sel   = scene_mode_t'(i_mode);
                    w_const_sel  = i_const_value;
                    w_valid_next = 1'b1;
                    w_load       = 1'b1;
                end
            end
            ST_STREAM: begin
                if (w_xfer) begin
                    if (w_frame_end) w_fc_next = w_fc_inc;
                    if (w_run_end) begin
                        w_state_next = ST_DONE;
                        w_valid_next = 1'b0;
                    end else begin
                        w_load = 1'b1;
                        if (w_beat_end) begin
                            w_beat_next = '0;
                            w_row_next  = w_row_end ? '0 : r_row + Y_W'(1);
                        end else begin
                            w_beat_next = r_beat + BEAT_W'(1);
                        end
                    end
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Pixels are computed for the beat about to be presented and captured into the output register.
    generate
        for (genvar gi = 0; gi < OUTPUT_BUS_WIDTH; gi++) begin : g_lane
            logic [X_W-1:0] w_x;
            assign w_x = X_W'(int'(w_beat_next) * OUTPUT_BUS_WIDTH + gi);
            scene_pixel_gen #(
                .PIXEL_BITS (PIXEL_BITS),
                .X_W        (X_W),
                .Y_W        (Y_W),
                .GRAD_STEP  (GRAD_STEP),
                .CHECK_LOG2 (CHECK_LOG2)
            ) u_pixel_gen (
                .i_mode        (w_mode_sel),
                .i_x           (w_x),
                .i_y           (w_row_next),
                .i_frame_count (w_fc_next),
                .i_const_value (w_const_sel),
                .o_pixel       (w_pixels[gi*PIXEL_BITS +: PIXEL_BITS])
            );
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_mode      <= CONSTANT;
            r_const     <= '0;
            r_frames    <= '0;
            r_stop_pend <= 1'b0;
            r_beat      <= '0;
            r_row       <= '0;
            r_fc        <= '0;
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_beat      <= w_beat_next;
            r_row       <= w_row_next;
            r_fc        <= w_fc_next;
            r_valid     <= w_valid_next;
            r_stop_pend <= (r_state == ST_STREAM) ? (r_stop_pend | i_stop) : 1'b0;
            if (r_state == ST_IDLE && i_start) begin
                r_mode   <= w_mode_sel;
                r_const  <= w_const_sel;
                r_frames <= i_frames;
            end
            if (w_load) begin
                r_data  <= w_pixels;
                r_first <= (w_beat_next == '0) && (w_row_next == '0);
                r_last  <= (w_beat_next == BEAT_W'(BPR - 1)) &&
                           (w_row_next == Y_W'(PIXEL_ARRAY_HEIGHT - 1));
            end else if (!w_valid_next) begin
                r_data  <= '0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign o_out_valid   = r_valid;
    assign o_out_data    = r_data;
    assign o_out_first   = r_first & r_valid;
    assign o_out_last    = r_last & r_valid;
    assign o_busy        = (r_state != ST_IDLE);
    assign o_done        = (r_state == ST_DONE);
    assign o_frame_count = r_fc;

endmodule

// File: tb/tb_scene_pattern_source.sv
// Directed bench for scene_pattern_source: pixel vector table plus multi-cycle handshake/run scenarios.
module tb_scene_pattern_source;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, out_ready;
    logic [1:0]  mode;
    logic [7:0]  const_value, frames;
    logic        out_valid, out_first, out_last, busy, done;
    logic [63:0] out_data;
    logic [7:0]  frame_count;

    always #5 clk = ~clk;

    scene_pattern_source dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_stop        (stop),
        .i_mode        (mode),
        .i_const_value (const_value),
        .i_frames      (frames),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_data    (out_data),
        .o_out_first   (out_first),
        .o_out_last    (out_last),
        .o_busy        (busy),
        .o_done        (done),
        .o_frame_count (frame_count)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [63:0] cap[$];
    int          first_idx[$];
    int          last_idx[$];
    int          done_cyc, done_cnt, stall_bad, stall_cnt;
    logic [7:0]  fc_done;
    logic        busy_after;

    task automatic run_job(input logic [1:0] m, input logic [7:0] cv, input logic [7:0] fr,
                           input bit toggle, input int stop_at, input bit start_stop,
                           input int reset_at, input int max_cyc);
        logic        prev_stall;
        logic [65:0] prev_snap;
        cap.delete(); first_idx.delete(); last_idx.delete();
        done_cyc = -1; done_cnt = 0; stall_bad = 0; stall_cnt = 0;
        fc_done = 8'h00; busy_after = 1'bx; prev_stall = 1'b0; prev_snap = '0;
        @(negedge clk);
        mode = m; const_value = cv; frames = fr; start = 1'b1; stop = start_stop; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            out_ready = toggle ? (c % 2 == 1) : 1'b1;
            stop      = (stop_at >= 0) && (cap.size() == stop_at) && out_valid;
            if (reset_at >= 0 && cap.size() == reset_at) break;
            if (prev_stall && ({out_data, out_first, out_last} !== prev_snap || !out_valid))
                stall_bad++;
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stall_cnt++;
            prev_snap = {out_data, out_first, out_last};
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    fc_done  = frame_count;
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = busy;
                break;
            end
            if (out_valid && out_ready) begin
                if (out_first) first_idx.push_back(cap.size());
                if (out_last)  last_idx.push_back(cap.size());
                cap.push_back(out_data);
            end
            @(negedge clk);
        end
        stop = 1'b0;
        out_ready = 1'b0;
    endtask

    function automatic logic [7:0] lane_of(input int idx, input int lane);
        logic [63:0] w;
        if (idx >= cap.size()) return 8'hxx;
        w = cap[idx];
        return w[lane*8 +: 8];
    endfunction

    typedef struct {
        logic [1:0] mode;
        logic [7:0] cval;
        logic [7:0] frames;
        int         idx;
        int         lane;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[13];

    initial begin
        int bad;
        logic [7:0] exp_px;

        // idx = frame*36 + row*3 + beat
        vecs[0]  = '{2'd1, 8'h00, 8'd1, 2,   7, 8'd230};
        vecs[1]  = '{2'd1, 8'h00, 8'd1, 3,   0, 8'd1};
        vecs[2]  = '{2'd1, 8'h00, 8'd1, 35,  7, 8'd241};
        vecs[3]  = '{2'd1, 8'h00, 8'd1, 0,   1, 8'd10};
        vecs[4]  = '{2'd2, 8'h00, 8'd1, 0,   0, 8'h00};
        vecs[5]  = '{2'd2, 8'h00, 8'd1, 0,   3, 8'h00};
        vecs[6]  = '{2'd2, 8'h00, 8'd1, 0,   4, 8'hFF};
        vecs[7]  = '{2'd2, 8'h00, 8'd1, 12,  0, 8'hFF};
        vecs[8]  = '{2'd2, 8'h00, 8'd1, 15,  4, 8'h00};
        vecs[9]  = '{2'd3, 8'h00, 8'd3, 72,  0, 8'd2};
        vecs[10] = '{2'd3, 8'h00, 8'd3, 107, 7, 8'd36};
        vecs[11] = '{2'd3, 8'h00, 8'd3, 36,  5, 8'd6};
        vecs[12] = '{2'd0, 8'hA5, 8'd1, 20,  3, 8'hA5};

        rst_n = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
        mode = 2'd0; const_value = 8'h00; frames = 8'd0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {out_valid, out_first, out_last, busy, done, frame_count, out_data}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // CONSTANT 0x5A, single frame
        run_job(2'd0, 8'h5A, 8'd1, 1'b0, -1, 1'b0, -1, 200);
        check("const_beats", cap.size(), 36);
        bad = 0;
        for (int i = 0; i < cap.size(); i++) if (cap[i] !== {8{8'h5A}}) bad++;
        check("const_all_lanes_bad", bad, 0);
        check("const_first_pos", (first_idx.size() == 1) ? first_idx[0] : -1, 0);
        check("const_last_pos", (last_idx.size() == 1) ? last_idx[0] : -1, 35);
        check("const_done_cycle", done_cyc, 37);
        check("const_done_width", done_cnt, 1);
        check("const_busy_after", busy_after, 1'b0);
        check("const_frame_count", fc_done, 8'd1);
        check("const_frame_count_held", frame_count, 8'd1);

        for (int v = 0; v < 13; v++) begin
            run_job(vecs[v].mode, vecs[v].cval, vecs[v].frames, 1'b0, -1, 1'b0, -1, 400);
            check($sformatf("pixel_vec%0d_idx%0d_lane%0d", v, vecs[v].idx, vecs[v].lane),
                  lane_of(vecs[v].idx, vecs[v].lane), vecs[v].exp);
            $display("vector %0d: mode=%0d idx=%0d lane=%0d px=0x%0h", v, vecs[v].mode,
                     vecs[v].idx, vecs[v].lane, lane_of(vecs[v].idx, vecs[v].lane));
        end

        // GRADIENT with out_ready alternating 1,0
        run_job(2'd1, 8'h00, 8'd1, 1'b1, -1, 1'b0, -1, 300);
        check("stall_beats", cap.size(), 36);
        bad = 0;
        for (int n = 0; n < cap.size(); n++) begin
            exp_px = 8'((n % 3) * 8 * 10 + n / 3);
            if (lane_of(n, 0) !== exp_px) bad++;
        end
        check("stall_sequence_bad", bad, 0);
        check("stall_hold_bad", stall_bad, 0);
        check("stall_seen", stall_cnt >= 30, 1'b1);
        check("stall_done_cycle", done_cyc, 72);

        // MOVING, three back-to-back frames
        run_job(2'd3, 8'h00, 8'd3, 1'b0, -1, 1'b0, -1, 400);
        check("moving_beats", cap.size(), 108);
        check("moving_done_cycle", done_cyc, 109);
        check("moving_frame_count", fc_done, 8'd3);
        check("moving_first_cnt", first_idx.size(), 3);
        check("moving_frame2_first", (first_idx.size() == 3) ? first_idx[2] : -1, 72);

        // Continuous mode with stop at frame 1 beat 10
        run_job(2'd3, 8'h00, 8'd0, 1'b0, 46, 1'b0, -1, 400);
        check("stop_beats", cap.size(), 72);
        check("stop_frame_count", fc_done, 8'd2);
        check("stop_last_cnt", last_idx.size(), 2);
        check("stop_busy_after", busy_after, 1'b0);

        // start together with stop in IDLE: stop ignored, both frames emitted
        run_job(2'd0, 8'h11, 8'd2, 1'b0, -1, 1'b1, -1, 300);
        check("startstop_beats", cap.size(), 72);
        check("startstop_frame_count", fc_done, 8'd2);

        // Asynchronous reset mid-frame, then restart
        run_job(2'd1, 8'h00, 8'd1, 1'b0, -1, 1'b0, 20, 200);
        check("prereset_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_clear",
              {out_valid, out_first, out_last, busy, done, frame_count, out_data}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_job(2'd1, 8'h00, 8'd1, 1'b0, -1, 1'b0, -1, 200);
        check("restart_beats", cap.size(), 36);
        check("restart_first_pos", (first_idx.size() == 1) ? first_idx[0] : -1, 0);
        check("restart_beat0_lane1", lane_of(0, 1), 8'd10);
        check("restart_frame_count", fc_done, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/scene_pattern_source.md
# scene_pattern_source

Synthesizable, parametrised scene generator for the pixel-sensor datapath. It replaces file-loaded and hard-coded scene constants with patterns generated on the fly. Frames are streamed row-major, OUTPUT_BUS_WIDTH pixels per beat, over a valid/ready handshake. The block feeds the readout and output-bus stages in simulation and on FPGA bring-up, with selectable pattern mode, frame count and continuous mode.

## Interface
- PIXEL_ARRAY_WIDTH, 24: pixels per row; must be a multiple of OUTPUT_BUS_WIDTH.
- PIXEL_ARRAY_HEIGHT, 12: rows per frame.
- PIXEL_BITS, 8: bits per pixel.
- OUTPUT_BUS_WIDTH, 8: pixels per beat (lanes).
- GRAD_STEP, 10: x increment for gradient mode.
- CHECK_LOG2, 2: checker square size is 2^CHECK_LOG2 pixels.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; sampled only in IDLE.
- stop  in  1  pulse; requests the end of the run after the current frame.
- mode  in  2  pattern select, latched at start: 0 CONSTANT, 1 GRADIENT, 2 CHECKER, 3 MOVING.
- const_value  in  PIXEL_BITS  pixel value for CONSTANT mode, latched at start.
- frames  in  8  frames to emit, latched at start; 0 means continuous until stop.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  OUTPUT_BUS_WIDTH*PIXEL_BITS  lane i at bits [i*PIXEL_BITS +: PIXEL_BITS] carries pixel x = beat*OUTPUT_BUS_WIDTH + i.
- out_first  out  1  first beat of a frame (x=0, y=0).
- out_last  out  1  last beat of a frame.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse when the run ends.
- frame_count  out  8  frames completed in the current or last run.

## Operation
- FSM states: IDLE, STREAM, DONE.
- IDLE → STREAM: start=1. On this edge, latch mode, const_value and frames; clear the beat, row and frame counters.
- STREAM: out_valid=1. A transfer occurs when out_valid & out_ready.
  - On each transfer the beat counter advances; it wraps at W/B−1 and increments the row.
  - The row wraps at H−1, which increments frame_count.
- STREAM → DONE: on the transfer of the last beat of a frame, when either:
  - frame_count+1 == frames (frames≠0), or
  - a stop is pending.
- DONE → IDLE: unconditional after one cycle. done=1 during DONE.
- stop is captured into a sticky pending flag during STREAM. It never truncates a frame. It is ignored in IDLE and DONE.
- start is ignored while busy. If start and stop arrive together in IDLE, start is honoured and stop is ignored.
- Pixel value per mode, all arithmetic truncated to PIXEL_BITS:
  - CONSTANT: const_value.
  - GRADIENT: x*GRAD_STEP + y.
  - CHECKER: all ones if ((x>>CHECK_LOG2) ^ (y>>CHECK_LOG2)) & 1, else 0.
  - MOVING: x + y + frame_count.
- frame_count saturates at 255 in continuous mode. The MOVING pattern then freezes its frame term.
- out_first = (beat==0 & row==0). out_last = (beat==W/B−1 & row==H−1). Both are qualified by out_valid.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, and every output is 0 (out_valid, out_data, out_first, out_last, busy, done, frame_count).
- Reset asserted mid-frame: outputs clear immediately and the partial frame is abandoned.
- start sampled at edge N: out_valid=1 and the first beat is presented after edge N; busy=1 from the same point.
- Beats are registered. out_data, out_first and out_last hold stable while out_valid & !out_ready.
- Frames are back-to-back: beat 0 of frame k+1 is presented in the cycle after the last beat of frame k is accepted.
- Transfer latency: one beat per cycle at out_ready=1. With default parameters a frame is H*W/B = 36 beats.
- done is high for exactly one cycle after the final accepted beat; busy falls in the same cycle that done falls.

## Structure
- Add to the PixelSensorConfig package:
  - typedef enum logic [1:0] scene_mode_t (CONSTANT, GRADIENT, CHECKER, MOVING);
  - the state enum;
  - default GRAD_STEP and CHECK_LOG2;
  - localparam BEATS_PER_ROW = PIXEL_ARRAY_WIDTH/OUTPUT_BUS_WIDTH.
- Sub-module scene_pixel_gen: a combinational pattern function of (mode, x, y, frame_count, const_value) → pixel. It is instantiated OUTPUT_BUS_WIDTH times in a generate loop.
- The top level holds the FSM, the counters and the output register.

## Test plan
- CONSTANT, const_value=8'h5A, frames=1, out_ready=1 → 36 beats, every lane 8'h5A; out_first on beat 0, out_last on beat 35; done pulse one cycle later; frame_count=1.
- GRADIENT → row 0 beat 2 lane 7 (x=23) = 230; row 1 beat 0 lane 0 = 1; row 11 beat 2 lane 7 = 241.
- CHECKER → row 0 beat 0 lanes 0-3 = 0, lanes 4-7 = 8'hFF; row 4 beat 0 lane 0 = 8'hFF.
- out_ready toggling 1,0,1,0 → out_data stable during stalls; exactly 36 unique beats, no duplicates or drops; done after 72 cycles.
- MOVING, frames=3 → frame 2 beat 0 lane 0 = 2; frames back-to-back with no bubble; frame_count=3 at done.
- frames=0, stop at beat 10 of frame 1 → frame 1 completes through beat 35, then done, then IDLE; frame_count=2.
- Reset low at beat 20 → all outputs 0 asynchronously; after release, start restarts at beat 0 of frame 0.
